// File: rtl/gbt_link_watchdog_if.sv
// Clock/reset bundle type and the channel-side signal bundle of the GBT link watchdog.
// Member names keep the watchdog's own port names so both sides read the same.
package gbt_link_watchdog_pkg;
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;
endpackage

interface gbt_link_watchdog_if #(
  parameter int g_channels      = 4,
  parameter int g_timeout_width = 11,
  parameter int g_retry_width   = 3
);
  logic [g_channels-1:0]               enable_i;
  logic [g_channels-1:0]               ready_i;
  logic [g_channels-1:0]               los_i;
  logic [g_timeout_width-1:0]          timeout_ms_i;
  logic                                clear_i;
  logic [g_channels-1:0]               rst_o;
  logic [g_channels-1:0]               locked_o;
  logic [g_channels-1:0]               failed_o;
  logic [g_channels*g_retry_width-1:0] retry_cnt_o;
  logic                                tick_o;

  modport master (
    output enable_i, ready_i, los_i, timeout_ms_i, clear_i,
    input  rst_o, locked_o, failed_o, retry_cnt_o, tick_o
  );

  modport slave (
    input  enable_i, ready_i, los_i, timeout_ms_i, clear_i,
    output rst_o, locked_o, failed_o, retry_cnt_o, tick_o
  );
endinterface

// File: rtl/gbt_link_watchdog.sv
// Multi-channel link watchdog: times out links that fail to come up, issues fixed
// reset pulses, counts consecutive retries and parks hopeless channels in FAILED.
module gbt_link_watchdog #(
  parameter int g_channels      = 4,
  parameter int g_tick_divider  = 120000,
  parameter int g_timeout_width = 11,
  parameter int g_pulse_cycles  = 16,
  parameter int g_max_retries   = 7,
  parameter int g_retry_width   = $clog2(g_max_retries + 1)
) (
  input  gbt_link_watchdog_pkg::ckrs_t ClkRs_ix,
  gbt_link_watchdog_if.slave           wd
);

  localparam int TCW = (g_tick_divider > 1) ? $clog2(g_tick_divider) : 1;
  localparam int PCW = (g_pulse_cycles > 1) ? $clog2(g_pulse_cycles) : 1;
  localparam logic [TCW-1:0]           TICK_LAST  = TCW'(g_tick_divider - 1);
  localparam logic [PCW-1:0]           PULSE_LAST = PCW'(g_pulse_cycles - 1);
  localparam logic [g_retry_width-1:0] RETRY_MAX  = g_retry_width'(g_max_retries);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LOCKED,
    ST_RESET,
    ST_FAILED
  } state_t;

  logic clk;
  logic srst;
  assign clk  = ClkRs_ix.clk;
  assign srst = ClkRs_ix.reset;

  logic [TCW-1:0]             tick_cnt_q, tick_cnt_d;
  logic                       tick_q, tick_d;
  logic [g_channels-1:0]      ready_q, ready_d;
  logic [g_channels-1:0]      los_q, los_d;
  logic [g_timeout_width-1:0] tmo_last;

  // tick_q mirrors "counter == last" so channels consume each tick exactly once
  always_comb begin
    tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TCW'(1);
    tick_d     = (tick_cnt_d == TICK_LAST);
    ready_d    = wd.ready_i;
    los_d      = wd.los_i;
    tmo_last   = (wd.timeout_ms_i == '0) ? '0 : wd.timeout_ms_i - g_timeout_width'(1);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      ready_q    <= '0;
      los_q      <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      ready_q    <= ready_d;
      los_q      <= los_d;
    end
  end

  logic [g_channels-1:0]               rst_vec;
  logic [g_channels-1:0]               locked_vec;
  logic [g_channels-1:0]               failed_vec;
  logic [g_channels*g_retry_width-1:0] retry_vec;

  for (genvar gi = 0; gi < g_channels; gi++) begin : g_ch
    state_t                     state_q, state_d;
    logic [g_timeout_width-1:0] timer_q, timer_d;
    logic [g_retry_width-1:0]   retry_q, retry_d;
    logic [PCW-1:0]             pulse_q, pulse_d;
    logic                       rst_q, locked_q, failed_q;

    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      retry_d = retry_q;
      pulse_d = pulse_q;
      if (!wd.enable_i[gi]) begin
        state_d = ST_IDLE;
        timer_d = '0;
        retry_d = '0;
        pulse_d = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d = ST_WAIT;
            timer_d = '0;
          end
          ST_WAIT: begin
            if (los_q[gi]) begin
              state_d = ST_RESET;
              pulse_d = '0;
            end else if (ready_q[gi]) begin
              state_d = ST_LOCKED;
              retry_d = '0;
            end else if (tick_q) begin
              // >= so a timeout lowered mid-wait still expires at the next tick
              if (timer_q >= tmo_last) begin
                if (retry_q == RETRY_MAX) begin
                  state_d = ST_FAILED;
                end else begin
                  state_d = ST_RESET;
                  retry_d = retry_q + g_retry_width'(1);
                  pulse_d = '0;
                end
              end else begin
                timer_d = timer_q + g_timeout_width'(1);
              end
            end
          end
          ST_LOCKED: begin
            retry_d = '0;
            if (los_q[gi]) begin
              state_d = ST_RESET;
              pulse_d = '0;
            end else if (!ready_q[gi]) begin
              state_d = ST_WAIT;
              timer_d = '0;
            end
          end
          ST_RESET: begin
            if (pulse_q == PULSE_LAST) begin
              state_d = ST_WAIT;
              timer_d = '0;
            end else begin
              pulse_d = pulse_q + PCW'(1);
            end
          end
          ST_FAILED: begin
            if (wd.clear_i) begin
              state_d = ST_WAIT;
              timer_d = '0;
              retry_d = '0;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (srst) begin
        state_q  <= ST_IDLE;
        timer_q  <= '0;
        retry_q  <= '0;
        pulse_q  <= '0;
        rst_q    <= 1'b0;
        locked_q <= 1'b0;
        failed_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        timer_q  <= timer_d;
        retry_q  <= retry_d;
        pulse_q  <= pulse_d;
        rst_q    <= (state_d == ST_RESET);
        locked_q <= (state_d == ST_LOCKED);
        failed_q <= (state_d == ST_FAILED);
      end
    end

    assign rst_vec[gi]    = rst_q;
    assign locked_vec[gi] = locked_q;
    assign failed_vec[gi] = failed_q;
    assign retry_vec[gi*g_retry_width +: g_retry_width] = retry_q;
  end

  assign wd.rst_o       = rst_vec;
  assign wd.locked_o    = locked_vec;
  assign wd.failed_o    = failed_vec;
  assign wd.retry_cnt_o = retry_vec;
  assign wd.tick_o      = tick_q;

endmodule

// File: tb/tb_gbt_link_watchdog.sv
// Directed plus randomised bench for gbt_link_watchdog: a behavioural reference model
// feeds a per-cycle scoreboard, and directed checks pin the documented timings.
module tb_gbt_link_watchdog;
  import gbt_link_watchdog_pkg::*;

  localparam int NCH  = 4;
  localparam int DIV  = 10;
  localparam int TW   = 11;
  localparam int PLS  = 4;
  localparam int MAXR = 2;
  localparam int RW   = 2;

  localparam int S_IDLE   = 0;
  localparam int S_WAIT   = 1;
  localparam int S_LOCKED = 2;
  localparam int S_RESET  = 3;
  localparam int S_FAILED = 4;

  typedef struct packed {
    logic [NCH-1:0]    rst;
    logic [NCH-1:0]    locked;
    logic [NCH-1:0]    failed;
    logic [NCH*RW-1:0] retry;
    logic              tick;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0] en, rdy, los;
  logic [TW-1:0]  tmo;
  logic           clr;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb_q[$];

  // reference model state
  int m_st[NCH];
  int m_ticks[NCH];
  int m_retry[NCH];
  int m_pulse[NCH];
  logic [NCH-1:0] m_rdy, m_los;
  int m_cnt;
  logic m_tick;

  always #5 clk = ~clk;

  gbt_link_watchdog_if #(.g_channels(NCH), .g_timeout_width(TW), .g_retry_width(RW)) wd_if ();

  assign wd_if.enable_i     = en;
  assign wd_if.ready_i      = rdy;
  assign wd_if.los_i        = los;
  assign wd_if.timeout_ms_i = tmo;
  assign wd_if.clear_i      = clr;

  gbt_link_watchdog #(
    .g_channels     (NCH),
    .g_tick_divider (DIV),
    .g_timeout_width(TW),
    .g_pulse_cycles (PLS),
    .g_max_retries  (MAXR),
    .g_retry_width  (RW)
  ) dut (
    .ClkRs_ix({clk, rst}),
    .wd      (wd_if)
  );

  task automatic model_edge();
    int lim;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_st[c] = S_IDLE; m_ticks[c] = 0; m_retry[c] = 0; m_pulse[c] = 0;
      end
      m_rdy = '0; m_los = '0; m_cnt = 0; m_tick = 1'b0;
      return;
    end
    lim = (tmo == 0) ? 1 : int'(tmo);
    for (int c = 0; c < NCH; c++) begin
      if (!en[c]) begin
        m_st[c] = S_IDLE; m_ticks[c] = 0; m_retry[c] = 0; m_pulse[c] = 0;
      end else begin
        case (m_st[c])
          S_IDLE: begin m_st[c] = S_WAIT; m_ticks[c] = 0; end
          S_WAIT: begin
            if (m_los[c]) begin
              m_st[c] = S_RESET; m_pulse[c] = 0;
            end else if (m_rdy[c]) begin
              m_st[c] = S_LOCKED; m_retry[c] = 0;
            end else if (m_tick) begin
              m_ticks[c]++;
              if (m_ticks[c] >= lim) begin
                if (m_retry[c] == MAXR) m_st[c] = S_FAILED;
                else begin m_retry[c]++; m_st[c] = S_RESET; m_pulse[c] = 0; end
              end
            end
          end
          S_LOCKED: begin
            if (m_los[c]) begin m_st[c] = S_RESET; m_pulse[c] = 0; end
            else if (!m_rdy[c]) begin m_st[c] = S_WAIT; m_ticks[c] = 0; end
          end
          S_RESET: begin
            m_pulse[c]++;
            if (m_pulse[c] == PLS) begin m_st[c] = S_WAIT; m_ticks[c] = 0; end
          end
          default: begin
            if (clr) begin m_st[c] = S_WAIT; m_ticks[c] = 0; m_retry[c] = 0; end
          end
        endcase
      end
    end
    m_rdy  = rdy;
    m_los  = los;
    m_cnt  = (m_cnt + 1) % DIV;
    m_tick = (m_cnt == DIV - 1);
  endtask

  function automatic exp_t build_exp();
    exp_t e;
    e = '0;
    for (int c = 0; c < NCH; c++) begin
      e.rst[c]    = (m_st[c] == S_RESET);
      e.locked[c] = (m_st[c] == S_LOCKED);
      e.failed[c] = (m_st[c] == S_FAILED);
      e.retry[c*RW +: RW] = RW'(m_retry[c]);
    end
    e.tick = m_tick;
    return e;
  endfunction

  // One clock: model follows the edge, expectation is queued, DUT is compared mid-cycle.
  task automatic step();
    exp_t e, got;
    @(posedge clk);
    model_edge();
    sb_q.push_back(build_exp());
    @(negedge clk);
    e   = sb_q.pop_front();
    got = {wd_if.rst_o, wd_if.locked_o, wd_if.failed_o, wd_if.retry_cnt_o, wd_if.tick_o};
    n_checks++;
    assert (got === e) else begin
      n_errors++;
      $error("FAIL scoreboard t=%0t got=%h exp=%h", $time, got, e);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    logic [31:0] e32;
    e32 = exp;
    n_checks++;
    assert (got === e32) else begin
      n_errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
    $display("chk %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic chk_range(input string tag, input int got, input int lo, input int hi);
    n_checks++;
    assert (got >= lo && got <= hi) else begin
      n_errors++;
      $error("FAIL %s got=%0d exp=[%0d..%0d]", tag, got, lo, hi);
    end
    $display("chk %s got=%0d exp=[%0d..%0d]", tag, got, lo, hi);
  endtask

  function automatic logic flag(input int which, input int ch);
    case (which)
      0:       return wd_if.rst_o[ch];
      1:       return wd_if.locked_o[ch];
      default: return wd_if.failed_o[ch];
    endcase
  endfunction

  function automatic logic [31:0] retry_of(input int ch);
    return 32'(wd_if.retry_cnt_o[ch*RW +: RW]);
  endfunction

  task automatic wait_flag(input int which, input int ch, input int budget, input string tag,
                           output int n, output int rst_seen);
    n = 0;
    rst_seen = 0;
    while (flag(which, ch) !== 1'b1 && n < budget) begin
      step();
      n++;
      if (wd_if.rst_o[ch] === 1'b1) rst_seen = 1;
    end
    chk({tag, "_seen"}, 32'(flag(which, ch)), 1);
  endtask

  task automatic pulse_len(input int ch, output int n);
    n = 0;
    while (wd_if.rst_o[ch] === 1'b1 && n < 50) begin
      n++;
      step();
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n, seen, ticks;
    rst = 1'b1; en = '0; rdy = '0; los = '0; tmo = TW'(3); clr = 1'b0;
    repeat (3) step();
    chk("reset_outputs", 32'({wd_if.rst_o, wd_if.locked_o, wd_if.failed_o,
                              wd_if.retry_cnt_o, wd_if.tick_o}), 0);

    // timeout retries on channel 0
    rst = 1'b0;
    en  = 4'b0001;
    step();
    wait_flag(0, 0, 40, "rst1", n, seen);
    chk_range("timeout1_delay", n, 2*DIV+1, 3*DIV);
    chk("retry_after_1", retry_of(0), 1);
    pulse_len(0, n);
    chk("pulse1_len", n, PLS);
    wait_flag(0, 0, 40, "rst2", n, seen);
    chk_range("timeout2_delay", n, 2*DIV+1, 3*DIV);
    chk("retry_after_2", retry_of(0), 2);
    pulse_len(0, n);
    chk("pulse2_len", n, PLS);
    wait_flag(2, 0, 40, "failed", n, seen);
    chk_range("fail_delay", n, 2*DIV+1, 3*DIV);
    chk("no_third_pulse", seen, 0);
    seen = 0;
    repeat (30) begin
      step();
      if (wd_if.rst_o[0] !== 1'b0) seen = 1;
    end
    chk("failed_quiet", seen, 0);
    chk("failed_held", 32'(wd_if.failed_o[0]), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clear_failed_drop", 32'(wd_if.failed_o[0]), 0);
    chk("clear_retry", retry_of(0), 0);
    wait_flag(0, 0, 40, "resume", n, seen);
    chk_range("resume_delay", n, 2*DIV+1, 3*DIV);
    chk("resume_retry", retry_of(0), 1);
    pulse_len(0, n);
    wait_flag(0, 0, 40, "rst_pre_late", n, seen);
    chk("retry_before_late", retry_of(0), 2);
    pulse_len(0, n);

    // late ready: arrives after the second of three ticks
    ticks = (wd_if.tick_o === 1'b1) ? 1 : 0;
    n = 0;
    while (ticks < 2 && n < 50) begin
      step();
      n++;
      if (wd_if.tick_o === 1'b1) ticks++;
    end
    chk("late_ticks_seen", ticks, 2);
    rdy[0] = 1'b1;
    step();
    chk("late_lock_lat1", 32'(wd_if.locked_o[0]), 0);
    step();
    chk("late_locked", 32'(wd_if.locked_o[0]), 1);
    chk("late_no_rst", 32'(wd_if.rst_o[0]), 0);
    chk("late_retry_clr", retry_of(0), 0);

    // loss of signal while locked
    los[0] = 1'b1;
    step();
    los[0] = 1'b0;
    chk("los_lat1_rst", 32'(wd_if.rst_o[0]), 0);
    step();
    chk("los_rst", 32'(wd_if.rst_o[0]), 1);
    chk("los_unlocked", 32'(wd_if.locked_o[0]), 0);
    chk("los_retry", retry_of(0), 0);
    pulse_len(0, n);
    chk("los_pulse_len", n, PLS);
    step();
    chk("relock", 32'(wd_if.locked_o[0]), 1);

    // mid-pulse enable drop and reset on channel 1, timeout 0 acting as 1
    tmo = '0;
    en[1] = 1'b1;
    step();
    wait_flag(0, 1, 20, "ch1_rst", n, seen);
    chk_range("tmo0_delay", n, 1, DIV);
    chk("ch1_retry", retry_of(1), 1);
    step();
    en[1] = 1'b0;
    step();
    chk("en_drop_rst", 32'(wd_if.rst_o[1]), 0);
    chk("en_drop_retry", retry_of(1), 0);
    en[1] = 1'b1;
    step();
    wait_flag(0, 1, 20, "ch1_rst2", n, seen);
    chk_range("tmo0_delay2", n, 1, DIV);
    step();
    rst = 1'b1;
    step();
    chk("reset_midpulse", 32'({wd_if.rst_o, wd_if.locked_o, wd_if.failed_o,
                               wd_if.retry_cnt_o, wd_if.tick_o}), 0);
    rst = 1'b0;

    // all channels, staggered random ready/los/enable/clear against the model
    en = 4'b1111; rdy = 4'b0101; tmo = TW'(2);
    for (int i = 0; i < 900; i++) begin
      if (i % 150 == 149) tmo = TW'($urandom_range(0, 2));
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 39) == 0) rdy[c] = ~rdy[c];
        los[c] = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 199) == 0) en[c] = ~en[c];
      end
      clr = ($urandom_range(0, 49) == 0);
      step();
    end
    clr = 1'b0;
    los = '0;
    $display("random phase done");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gbt_link_watchdog.md
# gbt_link_watchdog

Multi-channel, parametrised link watchdog and reset sequencer for GBT/MGT links. Each channel monitors a link-ready and a loss-of-signal flag. It issues a fixed-length reset pulse when the link fails to come up within a runtime-programmable millisecond timeout, or when signal is lost. Retries are counted per channel, and a channel is declared failed after a configurable number of consecutive unsuccessful retries. The block sits in the clock/reset system next to the MGT clock tree; its `rst_o` bits feed the per-link reset synchronisers and PLL resets.

## Interface
Parameters:
- `g_channels`, 4: number of independent monitored links.
- `g_tick_divider`, 120000: clock cycles per timeout tick (1 ms at 120 MHz).
- `g_timeout_width`, 11: width of the timeout value in ticks.
- `g_pulse_cycles`, 16: reset pulse length in clock cycles (≥1).
- `g_max_retries`, 7: consecutive timeout-driven resets allowed before a channel fails (≥1).
- `g_retry_width`, `$clog2(g_max_retries+1)`: width of each retry counter.

Ports:
- `ClkRs_ix`  input  ckrs_t  `.clk` is the single clock; `.reset` is a synchronous, active-high reset.
- `enable_i`  input  `g_channels`  per-channel enable; a low bit parks the channel in IDLE.
- `ready_i`  input  `g_channels`  link ready (rx_ready | tx_ready), already in the `ClkRs_ix` domain.
- `los_i`  input  `g_channels`  loss of signal, already in the `ClkRs_ix` domain.
- `timeout_ms_i`  input  `g_timeout_width`  timeout in ticks, shared by all channels; 0 is treated as 1.
- `clear_i`  input  1  single-cycle pulse; releases every FAILED channel.
- `rst_o`  output  `g_channels`  per-channel reset pulse.
- `locked_o`  output  `g_channels`  channel in LOCKED.
- `failed_o`  output  `g_channels`  channel in FAILED.
- `retry_cnt_o`  output  `g_channels*g_retry_width`  packed retry counters; channel c occupies `[c*g_retry_width +: g_retry_width]`.
- `tick_o`  output  1  one-cycle tick strobe.

## Operation
- **Tick generator.** A counter runs 0 … `g_tick_divider`-1 and wraps. `tick_o`=1 for the single cycle in which the counter equals `g_tick_divider`-1. The counter is free-running and shared by all channels.
- **Input registers.** `ready_i` and `los_i` each pass through one register stage (`ready_q`, `los_q`). The FSM uses only the registered values.
- **Per-channel FSM** (states IDLE, WAIT, LOCKED, RESET, FAILED). The enable rule has priority over every other transition.
  - Any state with `enable_i[c]`=0 → IDLE. In IDLE: timer=0, retry=0, pulse counter=0.
  - IDLE, `enable_i[c]`=1 → WAIT with timer=0.
  - WAIT:
    - `los_q` → RESET; retry is unchanged.
    - else `ready_q` → LOCKED.
    - else on tick: if timer == max(`timeout_ms_i`,1)-1, then → FAILED if retry == `g_max_retries`, otherwise → RESET with retry+1. If not at the limit, timer+1.
  - LOCKED:
    - Entry clears retry.
    - `los_q` → RESET.
    - Else `ready_q`=0 → WAIT with timer=0.
  - RESET: the pulse counter counts 0 … `g_pulse_cycles`-1, then → WAIT with timer=0. `ready_q` and `los_q` are ignored until the pulse completes.
  - FAILED:
    - Stays here; `rst_o`=0.
    - `clear_i` → WAIT with timer=0 and retry=0.
    - `los_q` is ignored.
- **Priority inside WAIT:** `los_q` > `ready_q` > timeout.
- **Timer width.** The timer is `g_timeout_width` bits and never wraps, because the compare fires first.
- **Retry counter.** `g_retry_width` bits; it never exceeds `g_max_retries`.
- **Outputs.** All outputs are registered and decoded from the registered next state:
  - `rst_o[c]` = (state==RESET)
  - `locked_o[c]` = (state==LOCKED)
  - `failed_o[c]` = (state==FAILED)
- **Reset** (`ClkRs_ix.reset`=1, synchronous). Every channel returns to IDLE. Tick counter, timers, retry counters and input registers go to 0. All outputs are 0, including `tick_o`. A reset mid-pulse truncates the `rst_o` pulse on the next edge.
- **Channel independence.** Channels share only the tick and `timeout_ms_i`. A change to `timeout_ms_i` takes effect at the next compare.

## Timing
- **`los_i` to `rst_o`.** `los_i` rising before edge k makes `rst_o` high after edge k+1 (2-cycle latency). The same latency applies from `ready_i` to `locked_o`.
- **Pulse length.** `rst_o` is high for exactly `g_pulse_cycles` consecutive cycles. It falls on the same edge that WAIT is re-entered.
- **Timeout.** A WAIT period with no `ready_q` and no `los_q` ends after exactly `timeout_ms_i` ticks. Measured from WAIT entry, the delay to the RESET transition is between (`timeout_ms_i`-1)·`g_tick_divider`+1 and `timeout_ms_i`·`g_tick_divider` cycles. The transition occurs on the edge that samples the terminal tick.
- **Enable deassertion.** `enable_i` low before edge k puts all outputs for that channel at 0 after edge k (one cycle, because the enable input is not registered).
- **`clear_i`.** The FAILED → WAIT transition and `failed_o` dropping occur on the same edge that samples `clear_i`.

## Test plan
- **Timeout retries.** Parameters: `g_tick_divider`=10, `g_max_retries`=2, `g_pulse_cycles`=4, `timeout_ms_i`=3, channel 0 enabled, `ready_i`=0 → `rst_o[0]` 4-cycle pulses, retry_cnt 1 then 2, then `failed_o[0]`=1 with no third pulse. `clear_i` pulse → WAIT, retry 0, pulses resume.
- **Loss of signal.** Channel locked, then `los_i[0]`=1 for 1 cycle → `rst_o[0]` high 2 cycles later for exactly `g_pulse_cycles`, retry_cnt unchanged. `locked_o[0]` 0 during the pulse.
- **Late ready.** `ready_i` arrives at tick 2 of 3 → `locked_o`=1 after 2 cycles with no reset. Retry counter at 2 from earlier timeouts → cleared on LOCKED entry.
- **Mid-pulse events.** `enable_i[1]`=0 mid-pulse → `rst_o[1]`=0 next cycle, counters 0. `ClkRs_ix.reset` mid-pulse → all outputs 0 next cycle.
- **Channel independence.** 4 channels with staggered ready/los → each channel's outputs match an independent reference model, with no cross-talk. `timeout_ms_i`=0 behaves identically to 1.
